// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and status-flag controller that wraps a dual-port RAM
// (port A write-only, port B read-only) into a synchronous FIFO.
module fifo_ctrl #(
  parameter int AW              = 3,
  parameter int DW              = 4,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          push,
  input  logic [DW-1:0] data_in,
  input  logic          pop,
  output logic [AW-1:0] addr_wr,
  output logic          rw_wr,
  output logic [DW-1:0] data_wr,
  output logic [AW-1:0] addr_rd,
  output logic          rw_rd,
  input  logic [DW-1:0] ram_data_rd,
  output logic [DW-1:0] data_out,
  output logic          valid_out,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          fifo_error
);

  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW + 1)'(ALMOST_FULL_TH);
  localparam logic [AW:0] AE_C    = (AW + 1)'(ALMOST_EMPTY_TH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;
  logic [AW:0]   count_nxt;
  logic          err_evt;

  // A pop on a full FIFO frees the slot the simultaneous push then uses.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign err_evt = (push & ~push_ok) | (pop & ~pop_ok);

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      fifo_error   <= 1'b0;
      valid_out    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
      fifo_error   <= fifo_error | err_evt;
      valid_out    <= pop_ok;
    end
  end

  assign addr_wr  = wr_ptr;
  assign rw_wr    = ~push_ok;
  assign data_wr  = data_in;
  assign addr_rd  = rd_ptr;
  assign rw_rd    = 1'b1;
  assign data_out = ram_data_rd;

endmodule
